// File: rtl/br_wb_arbiter.sv
// Writeback arbiter for the register bank write port, with a pending-write
// scoreboard that the issue stage uses to stall on RAW hazards.
module br_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   r0_valid,
  input  logic [ADDR_W-1:0]      r0_addr,
  input  logic [DATA_W-1:0]      r0_data,
  output logic                   r0_ready,
  input  logic                   r1_valid,
  input  logic [ADDR_W-1:0]      r1_addr,
  input  logic [DATA_W-1:0]      r1_data,
  output logic                   r1_ready,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [ADDR_W-1:0]      q1_addr,
  input  logic [ADDR_W-1:0]      q2_addr,
  output logic                   q1_busy,
  output logic                   q2_busy,
  output logic [(1<<ADDR_W)-1:0] pending,
  output logic [ADDR_W-1:0]      a3,
  output logic [DATA_W-1:0]      wd3,
  output logic                   we
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic            last_grant;
  logic            gnt0_c;
  logic            gnt1_c;
  logic [NREG-1:0] pending_nxt_c;

  // Round-robin grant; last_grant = 1 means requester 1 won most recently.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (r0_valid && r1_valid) begin
      gnt0_c = last_grant;
      gnt1_c = !last_grant;
    end else begin
      gnt0_c = r0_valid;
      gnt1_c = r1_valid;
    end
  end

  assign r0_ready = gnt0_c;
  assign r1_ready = gnt1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt0_c) begin
      last_grant <= 1'b0;
    end else if (gnt1_c) begin
      last_grant <= 1'b1;
    end
  end

  // Write stage: x0 transfers complete the handshake but never enable the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a3  <= '0;
      wd3 <= '0;
      we  <= 1'b0;
    end else if (gnt0_c) begin
      a3  <= r0_addr;
      wd3 <= r0_data;
      we  <= (r0_addr != '0);
    end else if (gnt1_c) begin
      a3  <= r1_addr;
      wd3 <= r1_data;
      we  <= (r1_addr != '0);
    end else begin
      we  <= 1'b0;
    end
  end

  // Clear on commit, then set on reservation so a newer owner wins the tie.
  always_comb begin
    pending_nxt_c = pending;
    if (we) begin
      pending_nxt_c[a3] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      pending_nxt_c[rsv_addr] = 1'b1;
    end
    pending_nxt_c[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt_c;
    end
  end

  assign q1_busy = pending[q1_addr];
  assign q2_busy = pending[q2_addr];

endmodule
